// File: rtl/cramer_pkg.sv
// cramer_pkg: shared types and sizing for the Cramer's-rule solver
package cramer_pkg;
  typedef enum logic [2:0] {IDLE, MUL, CHECK, DIV_X, DIV_Y, DONE} state_t;
  localparam int MUL_STEPS = 6;
  function automatic int calc_dw(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/cramer_divider.sv
// cramer_divider: N-cycle signed restoring divider; remainder port only with CRAMER_REMAINDER_EN
module cramer_divider #(
  parameter int N = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic signed [N-1:0] num_i,
  input  logic signed [N-1:0] den_i,
  output logic                done_o,
  output logic signed [N-1:0] quo_o
`ifdef CRAMER_REMAINDER_EN
  , output logic signed [N-1:0] rem_o
`endif
);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0] r_q, r_d, q_q, q_d, den_q, den_d, r_nx, q_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic qneg_q, qneg_d, nneg_q, nneg_d, ge;
  logic [N:0] sh;
  function automatic logic [N-1:0] mag(input logic signed [N-1:0] v);
    return v[N-1] ? -v : v;
  endfunction
  always_comb begin
    sh = {r_q, q_q[N-1]};
    ge = sh >= {1'b0, den_q};
    r_nx = ge ? N'(sh - {1'b0, den_q}) : sh[N-1:0];
    q_nx = {q_q[N-2:0], ge};
    done_o = cnt_q == CW'(1);
    // done_o marks the last step, so results are the combinational next values
    quo_o = qneg_q ? $signed(-q_nx) : $signed(q_nx);
    r_d = start_i ? '0 : (cnt_q != '0) ? r_nx : r_q;
    q_d = start_i ? mag(num_i) : (cnt_q != '0) ? q_nx : q_q;
    den_d = start_i ? mag(den_i) : den_q;
    qneg_d = start_i ? num_i[N-1] ^ den_i[N-1] : qneg_q;
    nneg_d = start_i ? num_i[N-1] : nneg_q;
    cnt_d = start_i ? CW'(N) : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
`ifdef CRAMER_REMAINDER_EN
  assign rem_o = nneg_q ? $signed(-r_nx) : $signed(r_nx);
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
      q_q <= '0;
      den_q <= '0;
      qneg_q <= 1'b0;
      nneg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      r_q <= r_d;
      q_q <= q_d;
      den_q <= den_d;
      qneg_q <= qneg_d;
      nneg_q <= nneg_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/cramer_solver.sv
// cramer_solver: sequential 2x2 Cramer's-rule solver with shared multiplier and divider
// Optional remainder outputs x_rem/y_rem enabled by CRAMER_REMAINDER_EN.
module cramer_solver
  import cramer_pkg::*;
#(
  parameter int WIDTH = 12,
  localparam int DW = calc_dw(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a11,
  input  logic signed [WIDTH-1:0] a12,
  input  logic signed [WIDTH-1:0] a21,
  input  logic signed [WIDTH-1:0] a22,
  input  logic signed [WIDTH-1:0] b1,
  input  logic signed [WIDTH-1:0] b2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    x_q,
  output logic signed [DW-1:0]    y_q,
  output logic signed [DW-1:0]    det,
  output logic                    singular
`ifdef CRAMER_REMAINDER_EN
  , output logic signed [DW-1:0]  x_rem
  , output logic signed [DW-1:0]  y_rem
`endif
);
  state_t state_q, state_d;
  logic [2:0] step_q, step_d;
  logic signed [WIDTH-1:0] a11_q, a12_q, a21_q, a22_q, b1_q, b2_q, m_a, m_b;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [DW-1:0] acc_q, det_q, dx_q, dy_q, diff, div_num, div_quo;
  logic accept, det_zero, div_start, div_done;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign accept = in_valid && in_ready;
  assign det = det_q;
  assign det_zero = det_q == '0;
  // Product order: D terms, then Dx terms, then Dy terms
  assign m_a = step_q == 3'd0 ? a11_q : step_q == 3'd1 ? a12_q : step_q == 3'd2 ? b1_q :
               step_q == 3'd3 ? a12_q : step_q == 3'd4 ? a11_q : b1_q;
  assign m_b = step_q == 3'd0 ? a22_q : step_q == 3'd1 ? a21_q : step_q == 3'd2 ? a22_q :
               step_q == 3'd3 ? b2_q : step_q == 3'd4 ? b2_q : a21_q;
  assign prod = m_a * m_b;
  assign diff = acc_q - DW'(prod);
  assign div_start = (state_q == CHECK && !det_zero) || (state_q == DIV_X && div_done);
  assign div_num = state_q == CHECK ? dx_q : dy_q;
`ifdef CRAMER_REMAINDER_EN
  logic signed [DW-1:0] div_rem;
`endif
  cramer_divider #(.N(DW)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(div_start),
    .num_i(div_num),
    .den_i(det_q),
    .done_o(div_done),
    .quo_o(div_quo)
`ifdef CRAMER_REMAINDER_EN
    , .rem_o(div_rem)
`endif
  );
  always_comb begin
    state_d = state_q;
    step_d = state_q == MUL ? step_q + 3'd1 : 3'd0;
    unique case (state_q)
      IDLE:    state_d = in_valid ? MUL : IDLE;
      MUL:     state_d = step_q == 3'(MUL_STEPS - 1) ? CHECK : MUL;
      CHECK:   state_d = det_zero ? DONE : DIV_X;
      DIV_X:   state_d = div_done ? DIV_Y : DIV_X;
      DIV_Y:   state_d = div_done ? DONE : DIV_Y;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      a11_q <= a11;
      a12_q <= a12;
      a21_q <= a21;
      a22_q <= a22;
      b1_q <= b1;
      b2_q <= b2;
    end
    if (state_q == MUL && !step_q[0]) acc_q <= DW'(prod);
    if (state_q == MUL && step_q == 3'd3) dx_q <= diff;
    if (state_q == MUL && step_q == 3'd5) dy_q <= diff;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      det_q <= '0;
      x_q <= '0;
      y_q <= '0;
      singular <= 1'b0;
`ifdef CRAMER_REMAINDER_EN
      x_rem <= '0;
      y_rem <= '0;
`endif
    end else begin
      if (state_q == MUL && step_q == 3'd1) det_q <= diff;
      if (state_q == CHECK) singular <= det_zero;
      if (state_q == CHECK && det_zero) begin
        x_q <= '0;
        y_q <= '0;
`ifdef CRAMER_REMAINDER_EN
        x_rem <= '0;
        y_rem <= '0;
`endif
      end
      if (state_q == DIV_X && div_done) x_q <= div_quo;
      if (state_q == DIV_Y && div_done) y_q <= div_quo;
`ifdef CRAMER_REMAINDER_EN
      if (state_q == DIV_X && div_done) x_rem <= div_rem;
      if (state_q == DIV_Y && div_done) y_rem <= div_rem;
`endif
    end
  end
endmodule

// File: tb/tb_cramer_solver.sv
// tb_cramer_solver: scoreboard bench for cramer_solver (remainders checked when CRAMER_REMAINDER_EN is defined)
module tb_cramer_solver;
  localparam int WIDTH = 12;
  localparam int DW = 2 * WIDTH + 1;
  typedef struct {
    longint det, x, y, xr, yr;
    bit sing;
    int lat;
    int acc;
  } exp_t;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, singular;
  logic signed [WIDTH-1:0] a11, a12, a21, a22, b1, b2;
  logic signed [DW-1:0] x_q, y_q, det;
`ifdef CRAMER_REMAINDER_EN
  logic signed [DW-1:0] x_rem, y_rem;
`endif
  int checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit seen = 0;
  cramer_solver #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a11(a11), .a12(a12), .a21(a21), .a22(a22), .b1(b1), .b2(b2),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_q(x_q), .y_q(y_q), .det(det), .singular(singular)
`ifdef CRAMER_REMAINDER_EN
    , .x_rem(x_rem), .y_rem(y_rem)
`endif
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic exp_t mk(input longint d, x, y, xr, yr, input bit s);
    exp_t e;
    e.det = d; e.x = x; e.y = y; e.xr = xr; e.yr = yr; e.sing = s;
    e.lat = s ? 7 : 7 + 2 * DW;
    e.acc = 0;
    return e;
  endfunction
  task automatic issue(input int v11, v12, v21, v22, vb1, vb2, input exp_t e, input bit push);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_wait", 0, 1);
    a11 = 12'(v11); a12 = 12'(v12); a21 = 12'(v21); a22 = 12'(v22); b1 = 12'(vb1); b2 = 12'(vb2);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    e.acc = cyc;
    if (push) sb.push_back(e);
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        mon_e = sb[0];
        if (!seen) chk("latency", longint'(cyc - mon_e.acc), longint'(mon_e.lat));
        seen = 1;
        chk("det", longint'(det), mon_e.det);
        chk("x_q", longint'(x_q), mon_e.x);
        chk("y_q", longint'(y_q), mon_e.y);
        chk("singular", longint'(singular), longint'(mon_e.sing));
`ifdef CRAMER_REMAINDER_EN
        chk("x_rem", longint'(x_rem), mon_e.xr);
        chk("y_rem", longint'(y_rem), mon_e.yr);
`endif
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end
  initial begin
    int n;
    rst_n = 0; in_valid = 0; out_ready = 1;
    a11 = 0; a12 = 0; a21 = 0; a22 = 0; b1 = 0; b2 = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_det", longint'(det), 0);
    chk("rst_x", longint'(x_q), 0);
    chk("rst_y", longint'(y_q), 0);
    chk("rst_singular", longint'(singular), 0);
    issue(2, 3, 1, -1, 8, -1, mk(-5, 1, 2, 0, 0, 0), 1);
    issue(1, 2, 2, 4, 3, 6, mk(0, 0, 0, 0, 0, 1), 1);
    issue(2, 0, 0, 1, -7, -3, mk(2, -3, -3, -1, 0, 0), 1);
    issue(-2048, 0, 0, -2048, -2048, 2047, mk(4194304, 1, 0, 0, -4192256, 0), 1);
    issue(3, 1, 1, -2, 10, -1, mk(-7, 2, 1, -5, -6, 0), 1);
    issue(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1), 1);
    // Stall in DONE with a competing request held on the input
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 0;
    issue(2, 3, 1, -1, 8, -1, mk(-5, 1, 2, 0, 0, 0), 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_reached_done", longint'(out_valid), 1);
    a11 = 5; a12 = 1; a21 = 1; a22 = 5; b1 = 1; b2 = 1;
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", longint'(in_ready), 0);
      chk("stall_out_valid", longint'(out_valid), 1);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("post_take_in_ready", longint'(in_ready), 1);
    chk("post_take_out_valid", longint'(out_valid), 0);
    // Reset while dividing x, then confirm a clean following operation
    issue(2, 3, 1, -1, 8, -1, mk(-5, 1, 2, 0, 0, 0), 0);
    repeat (20) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    chk("abort_in_ready", longint'(in_ready), 1);
    chk("abort_out_valid", longint'(out_valid), 0);
    rst_n = 1;
    issue(2, 0, 0, 1, -7, -3, mk(2, -3, -3, -1, 0, 0), 1);
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", longint'(sb.size()), 0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
